read_controller: RTL

- Frame read-back engine: on a start pulse, dumps the frame buffer over UART, the reverse path of the UART-to-BRAM write path.
- Reads NUM_PIXELS 24-bit words sequentially from the BRAM (spare read port, CLK100M domain).
- Splits each word into 3 bytes, R = [23:16] first, then G, then B.
- Hands each byte to an external UART transmitter using a start/busy handshake.

---
 rtl/image_processor_pkg.sv | 32 +++
 rtl/read_controller_if.sv | 15 +
 rtl/read_controller.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/image_processor_pkg.sv
// Shared types and frame constants for the image processor read-back path.
package image_processor_pkg;

  localparam int BYTES_PER_PIXEL = 3;
  localparam int FRAME_W         = 512;
  localparam int FRAME_H         = 384;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LATCH,
    SEND,
    ACK,
    WAIT,
    CHKSUM,
    FINISH
  } state_t;

  // Byte 0 is the most significant (red) channel.
  function automatic logic [7:0] pixel_byte(input logic [23:0] px, input logic [1:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      2'd0:    b = px[23:16];
      2'd1:    b = px[15:8];
      2'd2:    b = px[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/read_controller_if.sv
// BRAM read port plus UART transmitter handshake seen by the read controller.
interface read_controller_if #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 24
);
  logic                  en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;
  logic [7:0]            tx_data;
  logic                  tx_start;
  logic                  tx_busy;

  modport master (output en, addr, tx_data, tx_start, input din, tx_busy);
  modport slave  (input en, addr, tx_data, tx_start, output din, tx_busy);
endinterface

// File: rtl/read_controller.sv
// Frame read-back engine: streams NUM_PIXELS BRAM words as R,G,B bytes to a UART.
// Optional trailing checksum byte when READ_CHECKSUM_EN is defined.
module read_controller
  import image_processor_pkg::*;
#(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 24,
  parameter int NUM_PIXELS = 196608
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  read_controller_if.master   bus,
  output logic                busy,
  output logic                done
);

  // One extra bit so a full 2**ADDR_WIDTH frame never wraps the counter.
  localparam logic [ADDR_WIDTH:0] LAST_PIX = (ADDR_WIDTH + 1)'(NUM_PIXELS - 1);
  localparam logic [1:0]          LAST_BYTE = 2'(BYTES_PER_PIXEL - 1);

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH:0]     pix_cnt;
  logic [1:0]              byte_idx;
  logic [DATA_WIDTH-1:0]   pix_reg;

`ifdef READ_CHECKSUM_EN
  logic [7:0]              chk_sum;
  logic                    chk_phase;
`endif

  assign bus.addr = pix_cnt[ADDR_WIDTH-1:0];

`ifdef READ_CHECKSUM_EN
  assign bus.tx_data = chk_phase ? chk_sum : pixel_byte(pix_reg, byte_idx);
`else
  assign bus.tx_data = pixel_byte(pix_reg, byte_idx);
`endif

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    bus.en       = 1'b0;
    bus.tx_start = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = READ;
      end
      READ: begin
        bus.en    = 1'b1;
        state_nxt = LATCH;
      end
      LATCH: state_nxt = SEND;
      SEND: begin
        if (!bus.tx_busy) begin
          bus.tx_start = 1'b1;
          state_nxt    = ACK;
        end
      end
      ACK: state_nxt = WAIT;
      WAIT: begin
        if (!bus.tx_busy) begin
`ifdef READ_CHECKSUM_EN
          if (chk_phase)                state_nxt = FINISH;
          else if (byte_idx < LAST_BYTE) state_nxt = SEND;
          else if (pix_cnt < LAST_PIX)   state_nxt = READ;
          else                           state_nxt = CHKSUM;
`else
          if (byte_idx < LAST_BYTE)      state_nxt = SEND;
          else if (pix_cnt < LAST_PIX)   state_nxt = READ;
          else                           state_nxt = FINISH;
`endif
        end
      end
`ifdef READ_CHECKSUM_EN
      CHKSUM: state_nxt = SEND;
`endif
      FINISH: begin
        busy      = 1'b0;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pix_cnt  <= '0;
      byte_idx <= '0;
      pix_reg  <= '0;
`ifdef READ_CHECKSUM_EN
      chk_sum   <= '0;
      chk_phase <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (start) begin
            pix_cnt <= '0;
`ifdef READ_CHECKSUM_EN
            chk_sum   <= '0;
            chk_phase <= 1'b0;
`endif
          end
        end
        LATCH: begin
          pix_reg  <= bus.din;
          byte_idx <= '0;
        end
`ifdef READ_CHECKSUM_EN
        SEND: begin
          if (bus.tx_start && !chk_phase) chk_sum <= chk_sum + bus.tx_data;
        end
        CHKSUM: chk_phase <= 1'b1;
        WAIT: begin
          if (!bus.tx_busy && !chk_phase) begin
            if (byte_idx < LAST_BYTE)    byte_idx <= byte_idx + 2'd1;
            else if (pix_cnt < LAST_PIX) pix_cnt  <= pix_cnt + 1'b1;
          end
        end
`else
        WAIT: begin
          if (!bus.tx_busy) begin
            if (byte_idx < LAST_BYTE)    byte_idx <= byte_idx + 2'd1;
            else if (pix_cnt < LAST_PIX) pix_cnt  <= pix_cnt + 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
